// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain bitstream loader.
package ccff_bitstream_loader_pkg;

    localparam int unsigned DEFAULT_WORD_W    = 32;
    localparam int unsigned DEFAULT_CHAIN_LEN = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ccff_state_e;

    // Words needed to cover the chain in each direction.
    function automatic int unsigned ccff_num_words(input int unsigned chain_len,
                                                   input int unsigned word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Bits used from the final word; zero means the final word is full.
    function automatic int unsigned ccff_rem_bits(input int unsigned chain_len,
                                                  input int unsigned word_w);
        return chain_len % word_w;
    endfunction

endpackage

// File: rtl/ccff_word_serdes.sv
// Word-wide PISO feeding the chain head and SIPO packing the chain tail into readback words.
module ccff_word_serdes #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned IDX_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] load_data_i,
    input  logic [IDX_W-1:0]  load_bits_i,
    input  logic              shift_i,
    input  logic              final_i,
    input  logic              tail_i,
    input  logic              rd_ready_i,
    output logic              head_o,
    output logic              in_avail_o,
    output logic              in_last_o,
    output logic [WORD_W-1:0] rd_data_o,
    output logic              rd_valid_o
);

    localparam logic [WORD_W-1:0] MSB_ONE = {1'b1, {(WORD_W - 1){1'b0}}};

    logic [WORD_W-1:0] piso_q, piso_d;
    logic [IDX_W-1:0]  piso_cnt_q, piso_cnt_d;
    logic [WORD_W-1:0] sipo_q, sipo_d;
    logic [IDX_W-1:0]  sipo_cnt_q, sipo_cnt_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0] sipo_word;

    assign head_o     = piso_q[WORD_W-1];
    assign in_avail_o = piso_cnt_q != '0;
    assign in_last_o  = piso_cnt_q == IDX_W'(1);
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

    // Captured bit lands at its MSB-first slot, so a short final word is already left-justified.
    assign sipo_word = sipo_q | (tail_i ? (MSB_ONE >> sipo_cnt_q) : '0);

    always_comb begin
        piso_d     = piso_q;
        piso_cnt_d = piso_cnt_q;
        sipo_d     = sipo_q;
        sipo_cnt_d = sipo_cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q && !rd_ready_i;
        if (shift_i) begin
            piso_cnt_d = piso_cnt_q - IDX_W'(1);
            // The last bit stays on the head so it holds steady while starved.
            if (piso_cnt_q != IDX_W'(1)) begin
                piso_d = piso_q << 1;
            end
            if (sipo_cnt_q == IDX_W'(WORD_W - 1) || final_i) begin
                rd_data_d  = sipo_word;
                rd_valid_d = 1'b1;
                sipo_d     = '0;
                sipo_cnt_d = '0;
            end else begin
                sipo_d     = sipo_word;
                sipo_cnt_d = sipo_cnt_q + IDX_W'(1);
            end
        end
        if (load_i) begin
            piso_d     = load_data_i;
            piso_cnt_d = load_bits_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            piso_q     <= '0;
            piso_cnt_q <= '0;
            sipo_q     <= '0;
            sipo_cnt_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            piso_q     <= piso_d;
            piso_cnt_q <= piso_cnt_d;
            sipo_q     <= sipo_d;
            sipo_cnt_q <= sipo_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain initiator: streams a bitstream into ccff_head and returns the old contents from ccff_tail.
module ccff_bitstream_loader
    import ccff_bitstream_loader_pkg::*;
#(
    parameter int unsigned WORD_W    = DEFAULT_WORD_W,
    parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int unsigned NUM_WORDS = ccff_num_words(CHAIN_LEN, WORD_W);
    localparam int unsigned REM_BITS  = ccff_rem_bits(CHAIN_LEN, WORD_W);
    localparam int unsigned IDX_W     = $clog2(WORD_W + 1);
    localparam int unsigned WCNT_W    = $clog2(NUM_WORDS + 1);

    ccff_state_e       state_q, state_d;
    logic [CNT_W-1:0]  bit_count_q, bit_count_d;
    logic [WCNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              running;
    logic              in_avail;
    logic              in_last;
    logic              final_bit;
    logic              last_word;
    logic              wr_hs;
    logic              rd_hs;
    logic [IDX_W-1:0]  load_bits;

    assign running   = state_q == ST_RUN;
    assign final_bit = bit_count_q == CNT_W'(CHAIN_LEN - 1);
    assign last_word = wr_cnt_q == WCNT_W'(NUM_WORDS - 1);
    assign load_bits = (REM_BITS != 0 && last_word) ? IDX_W'(REM_BITS) : IDX_W'(WORD_W);

    assign shift_en = running && in_avail && (!rd_valid || rd_ready)
                      && (bit_count_q < CNT_W'(CHAIN_LEN));
    // Refill is allowed while the last bit of the held word is leaving, avoiding a bubble.
    assign wr_ready = running && (wr_cnt_q < WCNT_W'(NUM_WORDS))
                      && (!in_avail || (in_last && shift_en));
    assign wr_hs    = wr_valid && wr_ready;
    assign rd_hs    = rd_valid && rd_ready;

    assign busy      = busy_q;
    assign done      = done_q;
    assign bit_count = bit_count_q;

    ccff_word_serdes #(
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_serdes (
        .clk_i       (prog_clk),
        .rst_i       (prog_reset),
        .load_i      (wr_hs),
        .load_data_i (wr_data),
        .load_bits_i (load_bits),
        .shift_i     (shift_en),
        .final_i     (final_bit),
        .tail_i      (ccff_tail),
        .rd_ready_i  (rd_ready),
        .head_o      (ccff_head),
        .in_avail_o  (in_avail),
        .in_last_o   (in_last),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid)
    );

    always_comb begin
        state_d     = state_q;
        bit_count_d = bit_count_q;
        wr_cnt_d    = wr_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    bit_count_d = '0;
                    wr_cnt_d    = '0;
                    busy_d      = 1'b1;
                end
            end
            ST_RUN: begin
                if (wr_hs) begin
                    wr_cnt_d = wr_cnt_q + WCNT_W'(1);
                end
                if (shift_en) begin
                    bit_count_d = bit_count_q + CNT_W'(1);
                    if (final_bit) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (rd_hs) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q     <= ST_IDLE;
            bit_count_q <= '0;
            wr_cnt_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
            wr_cnt_q    <= wr_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule
